// File: rtl/lth_minmax_sched_pkg.sv
// Shared definitions for the streaming min/max sequencer: data width and FSM state encoding.
package lth_minmax_sched_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP_MIN = 2'd1,
    S_CMP_MAX = 2'd2,
    S_OUT     = 2'd3
  } state_t;
endpackage

// File: rtl/lth_8bit.sv
// Signed 8-bit less-than comparator: r_o = (x_i < y_i) in two's complement.
module lth_8bit (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic       r_o
);
  assign r_o = $signed(x_i) < $signed(y_i);
endmodule

// File: rtl/lth_minmax_sched.sv
// Frame min/max/count tracker that time-shares a single signed comparator
// between the running-minimum and running-maximum updates.
module lth_minmax_sched
  import lth_minmax_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_hold_q, last_hold_d;
  logic              first_q, first_d;

  logic [DATA_W-1:0] cmp_x, cmp_y;
  logic              cmp_r;
  logic              accept;

  // Operand routing: min phase asks hold<min, max phase asks max<hold.
  always_comb begin
    cmp_x = hold_q;
    cmp_y = min_q;
    if (state_q == S_CMP_MAX) begin
      cmp_x = max_q;
      cmp_y = hold_q;
    end
  end

  lth_8bit u_cmp (
    .x_i (cmp_x),
    .y_i (cmp_y),
    .r_o (cmp_r)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign accept    = in_valid & in_ready;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    hold_d      = hold_q;
    count_d     = count_q;
    last_hold_d = last_hold_q;
    first_d     = first_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (first_q) begin
            min_d   = in_data;
            max_d   = in_data;
            count_d = CNT_W'(1);
            first_d = 1'b0;
            if (in_last) state_d = S_OUT;
          end else begin
            hold_d      = in_data;
            last_hold_d = in_last;
            state_d     = S_CMP_MIN;
          end
        end
      end
      S_CMP_MIN: begin
        if (cmp_r) min_d = hold_q;
        state_d = S_CMP_MAX;
      end
      S_CMP_MAX: begin
        if (cmp_r) max_d = hold_q;
        if (!(&count_q)) count_d = count_q + CNT_W'(1);
        state_d = last_hold_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (out_ready) begin
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      min_q       <= '0;
      max_q       <= '0;
      hold_q      <= '0;
      count_q     <= '0;
      last_hold_q <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      last_hold_q <= last_hold_d;
      first_q     <= first_d;
    end
  end
endmodule

// File: tb/tb_lth_minmax_sched.sv
// Self-checking bench: table of frames with a result scoreboard, plus stall and mid-frame reset sequences.
module tb_lth_minmax_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  bit         sel = 1'b0;

  logic       in_ready1, out_valid1, in_ready2, out_valid2;
  logic [7:0] out_min1, out_max1, out_count1, out_min2, out_max2;
  logic [1:0] out_count2;

  always #5 clk = ~clk;

  lth_minmax_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready & ~sel),
    .out_min(out_min1), .out_max(out_max1), .out_count(out_count1)
  );

  lth_minmax_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready & sel),
    .out_min(out_min2), .out_max(out_max2), .out_count(out_count2)
  );

  logic       in_ready_m, out_valid_m;
  logic [7:0] out_min_m, out_max_m, out_count_m;
  assign in_ready_m  = sel ? in_ready2  : in_ready1;
  assign out_valid_m = sel ? out_valid2 : out_valid1;
  assign out_min_m   = sel ? out_min2   : out_min1;
  assign out_max_m   = sel ? out_max2   : out_max1;
  assign out_count_m = sel ? {6'b0, out_count2} : out_count1;

  typedef struct {
    bit         sel;
    int         n;
    logic [63:0] s;
    logic [7:0] emin;
    logic [7:0] emax;
    int         ecount;
    int         lat;
    int         hold;
  } vec_t;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] mx;
    int         cnt;
  } res_t;

  res_t sb[$];
  int   passed = 0;
  int   total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_m && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_m) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    res_t e;
    logic [7:0] smin, smax, scnt;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      e = '{8'h00, 8'h00, 0};
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_min"}, {24'd0, out_min_m}, {24'd0, e.mn});
    chk({tag, "_max"}, {24'd0, out_max_m}, {24'd0, e.mx});
    chk({tag, "_count"}, {24'd0, out_count_m}, e.cnt);
    chk({tag, "_in_ready_in_out"}, {31'd0, in_ready_m}, 32'd0);
    smin = out_min_m; smax = out_max_m; scnt = out_count_m;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, {31'd0, out_valid_m}, 32'd1);
      chk({tag, "_stall_ready"}, {31'd0, in_ready_m}, 32'd0);
      chk({tag, "_stall_stable"}, {8'd0, out_min_m, out_max_m, out_count_m}, {8'd0, smin, smax, scnt});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid_m}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, in_ready_m}, 32'd1);
    $display("frame %s: min=%02h max=%02h count=%0d", tag, smin, smax, scnt);
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int lat = 0;
    sel = v.sel;
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) sb.push_back('{v.emin, v.emax, v.ecount});
      send(v.s[8*i +: 8], i == v.n - 1);
    end
    while (!out_valid_m && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, v.lat);
    get_result(tag, v.hold);
  endtask

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 5, 64'h00_80_7F_FD_05, 8'h80, 8'h7F, 5, 2, 10};
    tbl[1] = '{0, 1, 64'hF9,             8'hF9, 8'hF9, 1, 0, 3};
    tbl[2] = '{0, 3, 64'h04_04_04,       8'h04, 8'h04, 3, 2, 0};
    tbl[3] = '{0, 3, 64'h03_FE_FF,       8'hFE, 8'h03, 3, 2, 0};
    tbl[4] = '{0, 2, 64'h80_80,          8'h80, 8'h80, 2, 2, 0};
    tbl[5] = '{1, 6, 64'h06_05_04_03_02_01, 8'h01, 8'h06, 3, 2, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready_m}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("rst_outputs", {8'd0, out_min_m, out_max_m, out_count_m}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_frame($sformatf("tbl%0d", k), tbl[k]);

    // Abort a frame while the first compare is in flight.
    sel = 1'b0;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {8'd0, out_min_m, out_max_m, out_count_m}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready_m}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_sb_clean", sb.size(), 32'd0);
    run_frame("after_abort", '{0, 1, 64'h02, 8'h02, 8'h02, 1, 0, 0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
